// File: rtl/game_state_ctrl.sv
// game_state_ctrl: one-hot game sequencer
// (idle -> L1 -> NL2 -> L2 -> NL3 -> L3 -> win/loss).
// It latches the kill count at each level entry and reports the kills made
// within the current level. It emits a one-cycle level_start strobe.
// Optional build macro GAME_STATE_AUTO_ADVANCE_EN: interludes also advance
// after INTERLUDE_FRAMES frame ticks.
module game_state_ctrl #(
    parameter int KILLS_L1         = 5,
    parameter int KILLS_L2         = 10,
    parameter int KILLS_L3         = 15,
    parameter int INTERLUDE_FRAMES = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        select_pulse,
    input  logic [15:0] zombies_killed,
    input  logic        zombie_breach,
    input  logic        frame_tick,
    output logic [7:0]  state,
    output logic [1:0]  level,
    output logic        level_start,
    output logic [15:0] kills_in_level,
    output logic        game_over
);

    typedef enum logic [7:0] {
        ST_I     = 8'h80,
        ST_L1    = 8'h40,
        ST_NL2   = 8'h20,
        ST_L2    = 8'h10,
        ST_NL3   = 8'h08,
        ST_L3    = 8'h04,
        ST_DONEL = 8'h02,
        ST_DONEW = 8'h01
    } state_t;

    localparam logic [15:0] TARGET_L1 = 16'(KILLS_L1);
    localparam logic [15:0] TARGET_L2 = 16'(KILLS_L2);
    localparam logic [15:0] TARGET_L3 = 16'(KILLS_L3);

    state_t      stateReg, stateNext;
    logic [1:0]  levelReg, levelNext;
    logic [15:0] baseReg, baseNext;
    logic        levelStartReg, levelStartNext;
    logic [15:0] killDelta;
    logic        inLevel;
    logic        interludeAdvance;

`ifdef GAME_STATE_AUTO_ADVANCE_EN
    localparam int CNT_W = $clog2(INTERLUDE_FRAMES + 1) < 1 ? 1 : $clog2(INTERLUDE_FRAMES + 1);
    localparam logic [CNT_W-1:0] FRAMES_MAX  = CNT_W'(INTERLUDE_FRAMES);
    localparam logic [CNT_W-1:0] FRAMES_LAST = FRAMES_MAX - 1'b1;

    logic [CNT_W-1:0] frameCntReg;
    logic             inInterlude;
    logic             autoAdvance;

    assign inInterlude = (stateReg == ST_NL2) || (stateReg == ST_NL3);

    // Interlude frame counter: zero outside interludes (so cleared on entry), saturating inside
    always_ff @(posedge clk) begin
        if (reset) begin
            frameCntReg <= '0;
        end else if (!inInterlude) begin
            frameCntReg <= '0;
        end else if (frame_tick && (frameCntReg < FRAMES_MAX)) begin
            frameCntReg <= frameCntReg + 1'b1;
        end
    end

    // Advance on the edge of the tick that makes the counter reach its limit,
    // so state moves one clock after the final tick (same latency as select)
    assign autoAdvance = (frameCntReg >= FRAMES_MAX) ||
                         (frame_tick && (frameCntReg == FRAMES_LAST));
    assign interludeAdvance = select_pulse || autoAdvance;
`else
    logic unusedFrameTick;
    assign unusedFrameTick  = frame_tick;
    assign interludeAdvance = select_pulse;
`endif

    assign inLevel   = (stateReg == ST_L1) || (stateReg == ST_L2) || (stateReg == ST_L3);
    // Modulo-2^16 subtraction handles wrap of the cumulative kill counter
    assign killDelta = zombies_killed - baseReg;

    // State, level, kill base and strobe registers
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg      <= ST_I;
            levelReg      <= 2'd0;
            baseReg       <= 16'd0;
            levelStartReg <= 1'b0;
        end else begin
            stateReg      <= stateNext;
            levelReg      <= levelNext;
            baseReg       <= baseNext;
            levelStartReg <= levelStartNext;
        end
    end

    // Next-state logic; breach is tested before the kill target so loss wins a tie
    always_comb begin
        stateNext      = stateReg;
        levelNext      = levelReg;
        baseNext       = baseReg;
        levelStartNext = 1'b0;
        case (stateReg)
            ST_I: begin
                if (select_pulse) begin
                    stateNext      = ST_L1;
                    levelNext      = 2'd1;
                    baseNext       = zombies_killed;
                    levelStartNext = 1'b1;
                end
            end
            ST_L1: begin
                if (zombie_breach)               stateNext = ST_DONEL;
                else if (killDelta >= TARGET_L1) stateNext = ST_NL2;
            end
            ST_NL2: begin
                if (interludeAdvance) begin
                    stateNext      = ST_L2;
                    levelNext      = 2'd2;
                    baseNext       = zombies_killed;
                    levelStartNext = 1'b1;
                end
            end
            ST_L2: begin
                if (zombie_breach)               stateNext = ST_DONEL;
                else if (killDelta >= TARGET_L2) stateNext = ST_NL3;
            end
            ST_NL3: begin
                if (interludeAdvance) begin
                    stateNext      = ST_L3;
                    levelNext      = 2'd3;
                    baseNext       = zombies_killed;
                    levelStartNext = 1'b1;
                end
            end
            ST_L3: begin
                if (zombie_breach)               stateNext = ST_DONEL;
                else if (killDelta >= TARGET_L3) stateNext = ST_DONEW;
            end
            ST_DONEL, ST_DONEW: begin
                if (select_pulse) begin
                    stateNext = ST_I;
                    levelNext = 2'd0;
                end
            end
            default: begin
                // Any non-one-hot encoding recovers to idle
                stateNext = ST_I;
                levelNext = 2'd0;
            end
        endcase
    end

    assign state          = stateReg;
    assign level          = levelReg;
    assign level_start    = levelStartReg;
    assign kills_in_level = inLevel ? killDelta : 16'd0;
    assign game_over      = (stateReg == ST_DONEL) || (stateReg == ST_DONEW);

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: directed self-checking bench for game_state_ctrl.
// The DUT runs with INTERLUDE_FRAMES=3. The interlude test follows
// GAME_STATE_AUTO_ADVANCE_EN.
module tb_game_state_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        select_pulse;
    logic [15:0] zombies_killed;
    logic        zombie_breach;
    logic        frame_tick;
    logic [7:0]  state;
    logic [1:0]  level;
    logic        level_start;
    logic [15:0] kills_in_level;
    logic        game_over;

    int nTests = 0;
    int nFail  = 0;

    game_state_ctrl #(
        .KILLS_L1(5), .KILLS_L2(10), .KILLS_L3(15), .INTERLUDE_FRAMES(3)
    ) dut (
        .clk(clk), .reset(reset), .select_pulse(select_pulse),
        .zombies_killed(zombies_killed), .zombie_breach(zombie_breach),
        .frame_tick(frame_tick), .state(state), .level(level),
        .level_start(level_start), .kills_in_level(kills_in_level),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_select();
        select_pulse = 1'b1;
        step();
        select_pulse = 1'b0;
        $display("[TB] select -> state=%h level=%0d start=%0b", state, level, level_start);
    endtask

    task automatic test_reset();
        reset = 1'b1; select_pulse = 1'b0; zombies_killed = 16'd0;
        zombie_breach = 1'b0; frame_tick = 1'b0;
        step(); step();
        reset = 1'b0;
        #1;
        nTests++; if (state !== 8'h80) begin nFail++; $display("FAIL reset_state: got %h expected %h", state, 8'h80); end
        nTests++; if (level !== 2'd0) begin nFail++; $display("FAIL reset_level: got %0d expected 0", level); end
        nTests++; if (game_over !== 1'b0 || level_start !== 1'b0) begin nFail++; $display("FAIL reset_flags: got go=%b ls=%b expected 0 0", game_over, level_start); end
        $display("[TB] reset -> state=%h", state);
    endtask

    task automatic test_level1();
        zombies_killed = 16'd100;
        pulse_select();
        nTests++; if (state !== 8'h40) begin nFail++; $display("FAIL l1_enter_state: got %h expected 40", state); end
        nTests++; if (level !== 2'd1) begin nFail++; $display("FAIL l1_level: got %0d expected 1", level); end
        nTests++; if (level_start !== 1'b1) begin nFail++; $display("FAIL l1_start_high: got %b expected 1", level_start); end
        nTests++; if (kills_in_level !== 16'd0) begin nFail++; $display("FAIL l1_kills0: got %0d expected 0", kills_in_level); end
        zombies_killed = 16'd104;
        step();
        nTests++; if (level_start !== 1'b0) begin nFail++; $display("FAIL l1_start_once: got %b expected 0", level_start); end
        nTests++; if (state !== 8'h40 || kills_in_level !== 16'd4) begin nFail++; $display("FAIL l1_below_target: got %h/%0d expected 40/4", state, kills_in_level); end
        zombies_killed = 16'd105;
        #1;
        nTests++; if (kills_in_level !== 16'd5) begin nFail++; $display("FAIL l1_kills5: got %0d expected 5", kills_in_level); end
        step();
        nTests++; if (state !== 8'h20) begin nFail++; $display("FAIL l1_to_nl2: got %h expected 20", state); end
        nTests++; if (level !== 2'd1 || kills_in_level !== 16'd0) begin nFail++; $display("FAIL nl2_level_kills: got %0d/%0d expected 1/0", level, kills_in_level); end
        $display("[TB] kills 105 -> state=%h", state);
    endtask

    task automatic test_interlude();
        // Breach is ignored in interludes
        zombie_breach = 1'b1;
        step();
        zombie_breach = 1'b0;
        nTests++; if (state !== 8'h20) begin nFail++; $display("FAIL nl2_breach_ignored: got %h expected 20", state); end
        for (int t = 1; t <= 3; t++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            $display("[TB] frame_tick %0d -> state=%h", t, state);
`ifdef GAME_STATE_AUTO_ADVANCE_EN
            if (t == 2) begin
                nTests++; if (state !== 8'h20) begin nFail++; $display("FAIL auto_early: got %h expected 20", state); end
            end
            if (t == 3) begin
                nTests++; if (state !== 8'h10 || level !== 2'd2) begin nFail++; $display("FAIL auto_advance: got %h/%0d expected 10/2", state, level); end
                nTests++; if (level_start !== 1'b1) begin nFail++; $display("FAIL auto_start: got %b expected 1", level_start); end
            end
`endif
            step();
        end
`ifndef GAME_STATE_AUTO_ADVANCE_EN
        nTests++; if (state !== 8'h20) begin nFail++; $display("FAIL no_auto_stay: got %h expected 20", state); end
        pulse_select();
        nTests++; if (state !== 8'h10 || level !== 2'd2) begin nFail++; $display("FAIL nl2_select: got %h/%0d expected 10/2", state, level); end
`endif
    endtask

    task automatic test_breach_tie();
        // Base latched at 105 on L2 entry
        zombies_killed = 16'd114;
        step();
        nTests++; if (state !== 8'h10 || kills_in_level !== 16'd9) begin nFail++; $display("FAIL l2_below: got %h/%0d expected 10/9", state, kills_in_level); end
        zombies_killed = 16'd115;
        zombie_breach  = 1'b1;
        step();
        zombie_breach = 1'b0;
        nTests++; if (state !== 8'h02) begin nFail++; $display("FAIL tie_loss: got %h expected 02", state); end
        nTests++; if (game_over !== 1'b1 || level !== 2'd2) begin nFail++; $display("FAIL donel_flags: got go=%b lvl=%0d expected 1 2", game_over, level); end
        step();
        nTests++; if (state !== 8'h02) begin nFail++; $display("FAIL donel_hold: got %h expected 02", state); end
        pulse_select();
        nTests++; if (state !== 8'h80 || level !== 2'd0 || level_start !== 1'b0) begin nFail++; $display("FAIL donel_to_i: got %h/%0d/%b expected 80/0/0", state, level, level_start); end
    endtask

    task automatic test_win_wrap();
        zombies_killed = 16'd200;
        pulse_select();
        zombies_killed = 16'd205;
        step();
        pulse_select();
        zombies_killed = 16'd300;
        step();
        nTests++; if (state !== 8'h08) begin nFail++; $display("FAIL reach_nl3: got %h expected 08", state); end
        zombies_killed = 16'hFFFE;
        pulse_select();
        nTests++; if (state !== 8'h04 || level !== 2'd3 || level_start !== 1'b1) begin nFail++; $display("FAIL l3_enter: got %h/%0d/%b expected 04/3/1", state, level, level_start); end
        pulse_select();
        nTests++; if (state !== 8'h04) begin nFail++; $display("FAIL l3_select_ignored: got %h expected 04", state); end
        for (int v = 1; v <= 15; v++) begin
            zombies_killed = 16'hFFFE + 16'(v);
            #1;
            nTests++; if (kills_in_level !== 16'(v)) begin nFail++; $display("FAIL wrap_kills_%0d: got %0d expected %0d", v, kills_in_level, v); end
            step();
            if (v == 14) begin
                nTests++; if (state !== 8'h04) begin nFail++; $display("FAIL l3_not_yet: got %h expected 04", state); end
            end
        end
        nTests++; if (state !== 8'h01 || game_over !== 1'b1) begin nFail++; $display("FAIL l3_win: got %h/%b expected 01/1", state, game_over); end
        $display("[TB] L3 delta 15 -> state=%h", state);
    endtask

    task automatic test_back_to_back();
        pulse_select();
        nTests++; if (state !== 8'h80 || level_start !== 1'b0 || level !== 2'd0) begin nFail++; $display("FAIL donew_to_i: got %h/%b/%0d expected 80/0/0", state, level_start, level); end
        zombies_killed = 16'h0020;
        pulse_select();
        nTests++; if (state !== 8'h40 || level_start !== 1'b1) begin nFail++; $display("FAIL restart_l1: got %h/%b expected 40/1", state, level_start); end
        zombies_killed = 16'h0022;
        #1;
        nTests++; if (kills_in_level !== 16'd2) begin nFail++; $display("FAIL fresh_base: got %0d expected 2", kills_in_level); end
    endtask

    task automatic test_reset_mid_level();
        zombies_killed = 16'h0025;
        step();
        pulse_select();
        nTests++; if (state !== 8'h10) begin nFail++; $display("FAIL mid_l2_setup: got %h expected 10", state); end
        reset = 1'b1; select_pulse = 1'b1;
        step(); step();
        reset = 1'b0; select_pulse = 1'b0;
        nTests++; if (state !== 8'h80 || level !== 2'd0) begin nFail++; $display("FAIL mid_reset_state: got %h/%0d expected 80/0", state, level); end
        nTests++; if (kills_in_level !== 16'd0 || game_over !== 1'b0 || level_start !== 1'b0) begin nFail++; $display("FAIL mid_reset_outs: got %0d/%b/%b expected 0/0/0", kills_in_level, game_over, level_start); end
        $display("[TB] reset mid-L2 -> state=%h", state);
    endtask

    initial begin
        test_reset();
        test_level1();
        test_interlude();
        test_breach_tie();
        test_win_wrap();
        test_back_to_back();
        test_reset_mid_level();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
